// File: rtl/m_dram_arbiter.sv
// m_dram_arbiter
// Round-robin arbiter that merges the DRAM request ports of NHARTS cores onto
// a single DRAM controller port. Each hart's one-cycle load/store pulse is
// latched, one hart at a time is granted, its fields are forwarded to the
// controller, and read data is broadcast back to all harts.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   w_h_addr/wdata/ctrl      per-hart request fields (hart i in slice i)
//   w_h_we, w_h_le           per-hart one-cycle write/load pulses
//   w_h_lock                 per-hart hold-grant request (ARB_LOCK_EN only)
//   w_h_busy                 per-hart busy (pulse | pending)
//   w_h_odata                last completed read data
//   w_grant                  index of the granted hart, zero-extended
//   w_m_addr/wdata/ctrl      fields to the DRAM controller
//   w_m_we, w_m_le           one-cycle pulses to the DRAM controller
//   w_m_busy, w_m_odata      controller busy and read data
//
// Build option
//   ARB_LOCK_EN  when defined, a hart holding w_h_lock in DONE keeps the
//                grant; other harts wait until it releases the lock.
//
// FSM states
//   state | meaning
//   IDLE  | pick next pending hart (round-robin after last)
//   ISSUE | one-cycle we/le pulse to the controller
//   WAIT  | wait for controller busy to rise and fall; capture read data
//   DONE  | clear the served hart's pending latch

module m_dram_arbiter #(
  parameter int NHARTS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [32*NHARTS-1:0]   w_h_addr,
  input  logic [32*NHARTS-1:0]   w_h_wdata,
  input  logic [3*NHARTS-1:0]    w_h_ctrl,
  input  logic [NHARTS-1:0]      w_h_we,
  input  logic [NHARTS-1:0]      w_h_le,
  input  logic [NHARTS-1:0]      w_h_lock,
  output logic [NHARTS-1:0]      w_h_busy,
  output logic [31:0]            w_h_odata,
  output logic [31:0]            w_grant,
  output logic [31:0]            w_m_addr,
  output logic [31:0]            w_m_wdata,
  output logic [2:0]             w_m_ctrl,
  output logic                   w_m_we,
  output logic                   w_m_le,
  input  logic                   w_m_busy,
  input  logic [31:0]            w_m_odata
);

  localparam int GW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic [NHARTS-1:0] pending;
  logic [NHARTS-1:0] p_we;
  logic [31:0]       p_addr  [NHARTS];
  logic [31:0]       p_wdata [NHARTS];
  logic [2:0]        p_ctrl  [NHARTS];

  logic [GW-1:0]     grant;
  logic [GW-1:0]     last;
  logic              saw_busy;

  logic [NHARTS-1:0] req;
  logic [NHARTS-1:0] clr;
  logic [GW-1:0]     rr_sel;
  logic              rr_found;
  logic [GW-1:0]     cand;
  logic [GW-1:0]     pick;
  logic              pick_valid;

`ifdef ARB_LOCK_EN
  logic              lock_hold;
`else
  logic              unused_lock;
  assign unused_lock = ^w_h_lock;
`endif

  assign req      = w_h_we | w_h_le;
  assign w_h_busy = req | pending;
  assign w_grant  = 32'(grant);

  assign w_m_addr  = p_addr[grant];
  assign w_m_wdata = p_wdata[grant];
  assign w_m_ctrl  = p_ctrl[grant];

  always_comb begin
    clr = '0;
    if (state == DONE) clr[grant] = 1'b1;
  end

  // First pending hart strictly after last, wrapping.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NHARTS; k++) begin
      cand = GW'((int'(last) + k) % NHARTS);
      if (!rr_found && pending[cand]) begin
        rr_sel   = cand;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    pick       = rr_sel;
    pick_valid = rr_found;
`ifdef ARB_LOCK_EN
    if (lock_hold) begin
      pick       = grant;
      pick_valid = pending[grant];
    end
`endif
  end

  // Pending latches. A pulse in the served hart's DONE cycle wins over the
  // clear so a back-to-back request is not lost; otherwise a pulse on an
  // already pending hart is ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < NHARTS; i++) begin
        if (req[i] && (!pending[i] || clr[i])) begin
          pending[i] <= 1'b1;
          p_we[i]    <= w_h_we[i];
          p_addr[i]  <= w_h_addr[32*i +: 32];
          p_wdata[i] <= w_h_wdata[32*i +: 32];
          p_ctrl[i]  <= w_h_ctrl[3*i +: 3];
        end else if (clr[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= GW'(NHARTS - 1);
      w_m_we    <= 1'b0;
      w_m_le    <= 1'b0;
      w_h_odata <= '0;
      saw_busy  <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_hold <= 1'b0;
`endif
    end else begin
      w_m_we <= 1'b0;
      w_m_le <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant  <= pick;
            last   <= pick;
            w_m_we <= p_we[pick];
            w_m_le <= ~p_we[pick];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          saw_busy <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          // Completion is the first idle cycle after the controller has
          // shown busy at least once.
          if (w_m_busy) begin
            saw_busy <= 1'b1;
          end else if (saw_busy) begin
            if (!p_we[grant]) w_h_odata <= w_m_odata;
            state <= DONE;
          end
        end
        DONE: begin
`ifdef ARB_LOCK_EN
          lock_hold <= w_h_lock[grant];
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
